guess_input_ctrl: RTL and testbench
===================================

Name: guess_input_ctrl

Overview:
Front end of the up/down guessing game, directly upstream of guess_compare_display.
- Synchronises and debounces four push buttons.
- Maintains the player's candidate number with up/down stepping and wrap-around.
- Draws the secret number from a free-running LFSR at the start of each game.
- Issues a one-cycle guess_trigger per accepted guess.
- user_number, actual_number and guess_trigger connect straight to the compare/display stage.

Parameters:
MAX_NUM, 99, largest selectable number; legal range 63..127 so that a single conditional subtract reduces the LFSR value.
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to accept a button level change; minimum 1.
LFSR_SEED, 7'h5A, LFSR reset value; must be nonzero.
MAX_ATTEMPTS, 7, guess limit per game; used only with GUESS_ATTEMPT_LIMIT_EN; range 1..15.

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
btn_up  input  1  raw increment button, asynchronous, may bounce
btn_down  input  1  raw decrement button, asynchronous, may bounce
btn_enter  input  1  raw submit-guess button
btn_new  input  1  raw new-game button
user_number  output  7  current candidate guess, 0..MAX_NUM
actual_number  output  7  secret number for current game, 0..MAX_NUM
guess_trigger  output  1  one-cycle pulse, guess submitted
attempt_count  output  4  guesses submitted in current game, saturates at 15
game_active  output  1  1 while in PLAY state

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; LFSR = LFSR_SEED; synchronisers, debounced levels and debounce counters = 0; FSM = IDLE.
- Button path, identical for each button:
  - 2-flop synchroniser feeds the debounce stage.
  - Debounced level flips only after the synchronised value has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing sample clears the counter.
  - A registered rising edge of the debounced level gives a one-cycle press pulse.
  - Fixed latency: input rising edge held stable → press pulse in cycle 3+DEBOUNCE_CYCLES, counted from the first clock edge that samples the new level as cycle 1.
  - Releases produce nothing. Holding a button gives exactly one press.
- LFSR:
  - 7-bit Fibonacci, taps x^7+x^6+1.
  - Steps every cycle in all states and never reaches 0.
  - Reduced value r = lfsr if lfsr ≤ MAX_NUM, else lfsr − (MAX_NUM+1).
- FSM IDLE:
  - game_active=0.
  - up/down presses still move user_number.
  - enter is ignored: no trigger, no count.
  - new press → PLAY. Same edge: actual_number ← r, attempt_count ← 0, user_number ← 0.
- FSM PLAY:
  - game_active=1.
  - enter press: guess_trigger=1 for exactly the next cycle. attempt_count increments on the same edge, so the new value is visible alongside the trigger. user_number is unchanged in that cycle.
  - new press: restart with the same updates as IDLE→PLAY; stays in PLAY.
- Candidate arithmetic, 7-bit:
  - up: MAX_NUM→0, otherwise +1.
  - down: 0→MAX_NUM, otherwise −1.
- Press priority within a single cycle: new > enter > up/down.
  - up and down pressed together: no change.
  - enter together with up or down: the up/down press is discarded.
- attempt_count saturates at 15 and never wraps.
- Reset asserted mid-game or mid-debounce: everything returns to reset values immediately. No press pulse is emitted for a button that is held through reset release until it has been debounced again from 0.

Optional Feature:
GUESS_ATTEMPT_LIMIT_EN
- Defined: when the enter press that raises attempt_count to MAX_ATTEMPTS is accepted, the trigger still fires. The FSM then returns to IDLE on that same edge, so game_active=0 in the trigger cycle. actual_number and attempt_count hold their values until the next new press.
- Undefined: no limit; PLAY persists until reset or new.
- Port list is identical in both builds.

Test Plan:
1. reset=0 for 10 cycles, random button activity → all outputs 0 throughout; after release, outputs remain 0 with no buttons pressed.
2. btn_up toggles every cycle for 10 cycles, then held high 8 cycles, DEBOUNCE_CYCLES=4 → user_number 0→1 exactly once; no pulse during the bounce.
3. From 0, one down press → 99. Then 100 up presses → wraps to 99 again, passing 0 once.
4. enter in IDLE → no guess_trigger, attempt_count stays 0.
5. new then enter → game_active=1, actual_number ≤ 99 and stable.
   - guess_trigger high exactly 1 cycle, 7 cycles after the enter edge.
   - attempt_count=1 in that cycle.
   - 16 more enters → count saturates at 15.
6. GUESS_ATTEMPT_LIMIT_EN, MAX_ATTEMPTS=3 → third enter fires trigger with game_active=0; fourth enter produces no trigger.
   - Separately, reset pulsed low during an up debounce (cycle 3 of 4) → user_number stays 0.

Source files
------------

// File: rtl/guess_input_ctrl.sv
// Button front end for the up/down guessing game: debounce, candidate stepping,
// LFSR secret draw and guess triggering. Optional macro: GUESS_ATTEMPT_LIMIT_EN.

module guess_btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_raw,
   output logic o_press
);
   localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_level_d;
   logic          r_press;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_press   <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         // Counter only runs while the synchronised sample disagrees with the level
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
         r_level_d <= r_level;
         r_press   <= r_level & ~r_level_d;
      end
   end

   assign o_press = r_press;
endmodule

module guess_input_ctrl #(
   parameter int         MAX_NUM         = 99,
   parameter int         DEBOUNCE_CYCLES = 4,
   parameter logic [6:0] LFSR_SEED       = 7'h5A,
   parameter int         MAX_ATTEMPTS    = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_enter,
   input  logic       btn_new,
   output logic [6:0] user_number,
   output logic [6:0] actual_number,
   output logic       guess_trigger,
   output logic [3:0] attempt_count,
   output logic       game_active
);
   localparam logic [6:0] MAXV = 7'(MAX_NUM);
   localparam logic [6:0] SPAN = 7'(MAX_NUM + 1);

   if (MAX_NUM < 63 || MAX_NUM > 127) begin : g_bad_max_num
      $error("MAX_NUM must lie in 63..127");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES must be at least 1");
   end
   if (LFSR_SEED == 7'h00) begin : g_bad_seed
      $error("LFSR_SEED must be nonzero");
   end
   if (MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 15) begin : g_bad_attempts
      $error("MAX_ATTEMPTS must lie in 1..15");
   end

   typedef enum logic {S_IDLE = 1'b0, S_PLAY = 1'b1} state_t;

   // Button order: 0 up, 1 down, 2 enter, 3 new
   logic [3:0] w_raw;
   logic [3:0] w_press;
   assign w_raw = {btn_new, btn_enter, btn_down, btn_up};

   for (genvar g = 0; g < 4; g++) begin : g_btn
      guess_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk    (clk),
         .rst_n  (reset),
         .i_raw  (w_raw[g]),
         .o_press(w_press[g])
      );
   end

   state_t     r_state, w_state_nxt;
   logic [6:0] r_lfsr;
   logic [6:0] r_user, w_user_nxt;
   logic [6:0] r_actual, w_actual_nxt;
   logic [3:0] r_count, w_count_nxt;
   logic       r_trig, w_trig_nxt;
   logic [6:0] w_lfsr_red;
   logic [3:0] w_count_inc;

   // One subtract suffices because MAX_NUM >= 63 keeps the 7-bit value below 2*(MAX_NUM+1)
   assign w_lfsr_red  = (r_lfsr > MAXV) ? (r_lfsr - SPAN) : r_lfsr;
   assign w_count_inc = (r_count == 4'hF) ? 4'hF : (r_count + 4'd1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_lfsr   <= LFSR_SEED;
         r_user   <= '0;
         r_actual <= '0;
         r_count  <= '0;
         r_trig   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_lfsr   <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
         r_user   <= w_user_nxt;
         r_actual <= w_actual_nxt;
         r_count  <= w_count_nxt;
         r_trig   <= w_trig_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_user_nxt   = r_user;
      w_actual_nxt = r_actual;
      w_count_nxt  = r_count;
      w_trig_nxt   = 1'b0;
      if (w_press[3]) begin
         w_state_nxt  = S_PLAY;
         w_actual_nxt = w_lfsr_red;
         w_count_nxt  = '0;
         w_user_nxt   = '0;
      end else if (w_press[2] && (r_state == S_PLAY)) begin
         w_trig_nxt  = 1'b1;
         w_count_nxt = w_count_inc;
`ifdef GUESS_ATTEMPT_LIMIT_EN
         if (w_count_inc >= 4'(MAX_ATTEMPTS)) begin
            w_state_nxt = S_IDLE;
         end
`endif
      end else if (w_press[0] && !w_press[1]) begin
         w_user_nxt = (r_user == MAXV) ? 7'd0 : (r_user + 7'd1);
      end else if (w_press[1] && !w_press[0]) begin
         w_user_nxt = (r_user == 7'd0) ? MAXV : (r_user - 7'd1);
      end
   end

   assign user_number   = r_user;
   assign actual_number = r_actual;
   assign guess_trigger = r_trig;
   assign attempt_count = r_count;
   assign game_active   = (r_state == S_PLAY);
endmodule

// File: tb/tb_guess_input_ctrl.sv
// Bench for guess_input_ctrl: history-window reference model checked every cycle
// plus directed scenarios with hand-computed expectations.

module tb_guess_input_ctrl;
   localparam int MAXN = 99;
   localparam int DEB  = 4;
`ifdef GUESS_ATTEMPT_LIMIT_EN
   localparam int MA   = 3;
`else
   localparam int MA   = 7;
`endif
   localparam int HLEN = 16384;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_up = 1'b0, btn_down = 1'b0, btn_enter = 1'b0, btn_new = 1'b0;
   logic [6:0] user_number, actual_number;
   logic       guess_trigger, game_active;
   logic [3:0] attempt_count;

   int checks = 0;
   int errors = 0;

   guess_input_ctrl #(
      .MAX_NUM(MAXN), .DEBOUNCE_CYCLES(DEB), .LFSR_SEED(7'h5A), .MAX_ATTEMPTS(MA)
   ) dut (
      .clk(clk), .reset(reset),
      .btn_up(btn_up), .btn_down(btn_down), .btn_enter(btn_enter), .btn_new(btn_new),
      .user_number(user_number), .actual_number(actual_number),
      .guess_trigger(guess_trigger), .attempt_count(attempt_count),
      .game_active(game_active)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: per-edge history of raw samples and debounced levels
   bit raw_h [4][HLEN];
   bit lvl_h [4][HLEN];
   int t = 8;
   int m_user = 0, m_actual = 0, m_count = 0, m_lfsr = 'h5A;
   bit m_trig = 0, m_active = 0;

   function automatic int reduce(input int l);
      return (l > MAXN) ? l - (MAXN + 1) : l;
   endfunction

   always @(posedge clk) begin
      bit bt[4];
      bit pr[4];
      bit flip;
      bt = '{btn_up, btn_down, btn_enter, btn_new};
      t++;
      for (int b = 0; b < 4; b++) begin
         if (!reset) begin
            raw_h[b][t] = 1'b0;
            lvl_h[b][t] = 1'b0;
         end else begin
            raw_h[b][t] = bt[b];
            // Level flips once the last DEB synchronised samples (two edges old) all disagree
            flip = 1'b1;
            for (int k = 0; k < DEB; k++)
               if (raw_h[b][t-2-k] == lvl_h[b][t-1]) flip = 1'b0;
            lvl_h[b][t] = flip ? ~lvl_h[b][t-1] : lvl_h[b][t-1];
         end
         pr[b] = lvl_h[b][t-2] && !lvl_h[b][t-3];
      end
      m_trig = 1'b0;
      if (!reset) begin
         m_user = 0; m_actual = 0; m_count = 0; m_active = 0; m_lfsr = 'h5A;
      end else begin
         if (pr[3]) begin
            m_active = 1; m_actual = reduce(m_lfsr); m_count = 0; m_user = 0;
         end else if (pr[2] && m_active) begin
            m_trig  = 1'b1;
            m_count = (m_count < 15) ? m_count + 1 : 15;
`ifdef GUESS_ATTEMPT_LIMIT_EN
            if (m_count >= MA) m_active = 0;
`endif
         end else if (pr[0] && !pr[1]) begin
            m_user = (m_user == MAXN) ? 0 : m_user + 1;
         end else if (pr[1] && !pr[0]) begin
            m_user = (m_user == 0) ? MAXN : m_user - 1;
         end
         m_lfsr = ((m_lfsr << 1) & 'h7F) | (((m_lfsr >> 6) ^ (m_lfsr >> 5)) & 1);
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         chk("cyc_user",   int'(user_number),   m_user);
         chk("cyc_actual", int'(actual_number), m_actual);
         chk("cyc_trig",   int'(guess_trigger), int'(m_trig));
         chk("cyc_count",  int'(attempt_count), m_count);
         chk("cyc_active", int'(game_active),   int'(m_active));
      end else begin
         chk("rst_user",   int'(user_number),   0);
         chk("rst_actual", int'(actual_number), 0);
         chk("rst_trig",   int'(guess_trigger), 0);
         chk("rst_count",  int'(attempt_count), 0);
         chk("rst_active", int'(game_active),   0);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_btn(input int b, input logic v);
      case (b)
         0: btn_up    = v;
         1: btn_down  = v;
         2: btn_enter = v;
         default: btn_new = v;
      endcase
   endtask

   task automatic press(input int b);
      set_btn(b, 1'b1);
      tick(10);
      set_btn(b, 1'b0);
      tick(10);
   endtask

   // Hold enter for 10 cycles, watch 20 cycles for the trigger
   task automatic enter_measure(output int lat, output int ntrig,
                                output int cnt_at, output int act_at);
      lat = 0; ntrig = 0; cnt_at = -1; act_at = -1;
      btn_enter = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (guess_trigger) begin
            if (ntrig == 0) begin
               lat = k; cnt_at = int'(attempt_count); act_at = int'(game_active);
            end
            ntrig++;
         end
         if (k == 10) btn_enter = 1'b0;
      end
   endtask

   initial begin
      int lat, ntrig, cnt_at, act_at, secret;

      // Reset with random button activity
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         {btn_up, btn_down, btn_enter, btn_new} = 4'($urandom);
      end
      @(negedge clk);
      {btn_up, btn_down, btn_enter, btn_new} = 4'b0;
      #1 reset = 1'b1;
      tick(12);
      chk("idle_user",   int'(user_number),   0);
      chk("idle_actual", int'(actual_number), 0);
      chk("idle_active", int'(game_active),   0);

      // Bouncing up button, then a stable hold: exactly one step
      for (int i = 0; i < 10; i++) begin
         btn_up = (i % 2 == 1);
         tick(1);
      end
      btn_up = 1'b1;
      tick(8);
      btn_up = 1'b0;
      tick(12);
      chk("bounce_user", int'(user_number), 1);

      // Back to 0, then wrap down, then a full lap upward
      press(1);
      chk("down_from1", int'(user_number), 0);
      press(1);
      chk("down_wrap", int'(user_number), 99);
      press(0);
      chk("up_wrap", int'(user_number), 0);
      for (int i = 0; i < 99; i++) press(0);
      chk("up_lap", int'(user_number), 99);

      // Enter is ignored while idle
      press(2);
      chk("idle_enter_count",  int'(attempt_count), 0);
      chk("idle_enter_active", int'(game_active),   0);

      // New game, then a guess
      press(3);
      chk("new_active", int'(game_active), 1);
      chk("new_user",   int'(user_number), 0);
      chk("new_range",  int'(actual_number <= 7'd99), 1);
      secret = int'(actual_number);
      enter_measure(lat, ntrig, cnt_at, act_at);
      chk("trig_latency", lat, 8);
      chk("trig_width",   ntrig, 1);
      chk("trig_count",   cnt_at, 1);
      chk("trig_active",  act_at, 1);
      chk("secret_hold",  int'(actual_number), secret);

`ifdef GUESS_ATTEMPT_LIMIT_EN
      enter_measure(lat, ntrig, cnt_at, act_at);
      chk("lim2_trig",   ntrig, 1);
      chk("lim2_count",  cnt_at, 2);
      chk("lim2_active", act_at, 1);
      enter_measure(lat, ntrig, cnt_at, act_at);
      chk("lim3_trig",   ntrig, 1);
      chk("lim3_count",  cnt_at, 3);
      chk("lim3_active", act_at, 0);
      enter_measure(lat, ntrig, cnt_at, act_at);
      chk("lim4_trig",   ntrig, 0);
      chk("lim4_count",  int'(attempt_count), 3);
      chk("lim4_secret", int'(actual_number), secret);
`else
      for (int i = 0; i < 16; i++) press(2);
      chk("sat_count",  int'(attempt_count), 15);
      chk("sat_active", int'(game_active),   1);
      chk("sat_secret", int'(actual_number), secret);
`endif

      // Reset landing in the middle of an up debounce
      btn_up = 1'b1;
      tick(5);
      #1 reset = 1'b0;
      btn_up = 1'b0;
      tick(3);
      #1 reset = 1'b1;
      tick(15);
      chk("rst_mid_user",   int'(user_number),   0);
      chk("rst_mid_count",  int'(attempt_count), 0);
      chk("rst_mid_active", int'(game_active),   0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
